// File: rtl/mvd_search_sched.sv
// mvd_search_sched: full-search motion-vector candidate scheduler.
// Walks a (2R+1)^2 square window around a latched centre, issues candidates
// to an external cost datapath with a bounded number in flight, tracks the
// issued coordinates in a tag FIFO, and keeps the lowest-cost candidate.
module mvd_search_sched #(
  parameter int MAX_OUT = 4,
  parameter int RANGE_W = 4
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               ap_start,
  input  logic               abort,
  input  logic [15:0]        center_x,
  input  logic [15:0]        center_y,
  input  logic [RANGE_W-1:0] range,
  output logic               cost_start,
  output logic [15:0]        cost_x,
  output logic [15:0]        cost_y,
  input  logic               cost_vld,
  input  logic [63:0]        cost_val,
  output logic               ap_idle,
  output logic               ap_ready,
  output logic               ap_done,
  output logic [15:0]        best_x,
  output logic [15:0]        best_y,
  output logic [63:0]        best_cost,
  output logic [15:0]        eval_cnt,
  output logic               aborted,
  output logic               err_sticky
);

  localparam int AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int OW = RANGE_W + 1;
  localparam logic [AW:0]   MAX_CNT   = (AW+1)'(MAX_OUT);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [OW-1:0] OFF_ONE   = OW'(1);
  localparam logic [63:0]   COST_INIT = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     cx_q, cx_d, cy_q, cy_d;
  logic [RANGE_W-1:0] r_q, r_d;
  logic [OW-1:0]   dx_q, dx_d, dy_q, dy_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     out_cnt_q, out_cnt_d;
  logic [15:0]     tag_x_q [MAX_OUT];
  logic [15:0]     tag_y_q [MAX_OUT];
  logic            first_q, first_d;
  logic [15:0]     best_x_q, best_x_d, best_y_q, best_y_d;
  logic [63:0]     best_cost_q, best_cost_d;
  logic [15:0]     eval_cnt_q, eval_cnt_d;
  logic            aborted_q, aborted_d, err_q, err_d;
  logic            ap_idle_q, ap_idle_d, ap_done_q, ap_done_d;
  logic            issue_s, accept_s, last_s;
  logic [OW-1:0]   r_ext_s, start_neg_s;

  // Candidate coordinates: centre plus sign-extended offset, wrapping mod 2^16.
  assign r_ext_s     = {1'b0, r_q};
  assign start_neg_s = {OW{1'b0}} - {1'b0, range};
  assign last_s      = (dx_q == r_ext_s) && (dy_q == r_ext_s);
  assign cost_x      = cx_q + {{(16-OW){dx_q[OW-1]}}, dx_q};
  assign cost_y      = cy_q + {{(16-OW){dy_q[OW-1]}}, dy_q};
  assign cost_start  = issue_s;

  // Issue/accept qualification: a returning result frees a slot in the same cycle.
  always_comb begin
    issue_s  = 1'b0;
    accept_s = cost_vld && (state_q == S_ISSUE || state_q == S_DRAIN) && (out_cnt_q != '0);
    if (state_q == S_ISSUE && !abort) begin
      if (out_cnt_q < MAX_CNT) issue_s = 1'b1;
      else                     issue_s = cost_vld;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Next-state, window walk, tag bookkeeping and best-candidate tracking.
  always_comb begin
    state_d     = state_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    r_d         = r_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_cnt_d   = out_cnt_q;
    first_d     = first_q;
    best_x_d    = best_x_q;
    best_y_d    = best_y_q;
    best_cost_d = best_cost_q;
    eval_cnt_d  = eval_cnt_q;
    aborted_d   = aborted_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          cx_d        = center_x;
          cy_d        = center_y;
          r_d         = range;
          dx_d        = start_neg_s;
          dy_d        = start_neg_s;
          first_d     = 1'b1;
          best_x_d    = 16'd0;
          best_y_d    = 16'd0;
          best_cost_d = COST_INIT;
          eval_cnt_d  = 16'd0;
          aborted_d   = 1'b0;
          err_d       = 1'b0;
          state_d     = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DRAIN;
        end else if (issue_s) begin
          if (last_s) begin
            state_d = S_DRAIN;
          end else if (dx_q == r_ext_s) begin
            dx_d = {OW{1'b0}} - r_ext_s;
            dy_d = dy_q + OFF_ONE;
          end else begin
            dx_d = dx_q + OFF_ONE;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (out_cnt_q == '0) state_d = S_DONE;
        else                 state_d = S_DRAIN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept_s) begin
      if (first_q || (cost_val < best_cost_q)) begin
        best_x_d    = tag_x_q[rd_ptr_q];
        best_y_d    = tag_y_q[rd_ptr_q];
        best_cost_d = cost_val;
      end else begin
        best_cost_d = best_cost_d;
      end
      first_d = 1'b0;
      if (eval_cnt_q != 16'hFFFF) eval_cnt_d = eval_cnt_q + 16'd1;
      else                        eval_cnt_d = eval_cnt_q;
    end else if (cost_vld) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end

    if (issue_s)  wr_ptr_d = wr_ptr_q + PTR_ONE;
    else          wr_ptr_d = wr_ptr_q;
    if (accept_s) rd_ptr_d = rd_ptr_q + PTR_ONE;
    else          rd_ptr_d = rd_ptr_q;

    case ({issue_s, accept_s})
      2'b10:   out_cnt_d = out_cnt_q + CNT_ONE;
      2'b01:   out_cnt_d = out_cnt_q - CNT_ONE;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // Handshake flags are registered decodes of the next state.
  always_comb begin
    ap_idle_d = (state_d == S_IDLE);
    ap_done_d = (state_d == S_DONE);
  end

  // Tag FIFO storage: coordinates of each issued candidate, read back in order.
  always_ff @(posedge ap_clk) begin
    if (issue_s) begin
      tag_x_q[wr_ptr_q] <= cost_x;
      tag_y_q[wr_ptr_q] <= cost_y;
    end
  end

  // Control and result state with asynchronous reset.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= S_IDLE;
      cx_q        <= 16'd0;
      cy_q        <= 16'd0;
      r_q         <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_cnt_q   <= '0;
      first_q     <= 1'b1;
      best_x_q    <= 16'd0;
      best_y_q    <= 16'd0;
      best_cost_q <= COST_INIT;
      eval_cnt_q  <= 16'd0;
      aborted_q   <= 1'b0;
      err_q       <= 1'b0;
      ap_idle_q   <= 1'b1;
      ap_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      r_q         <= r_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_cnt_q   <= out_cnt_d;
      first_q     <= first_d;
      best_x_q    <= best_x_d;
      best_y_q    <= best_y_d;
      best_cost_q <= best_cost_d;
      eval_cnt_q  <= eval_cnt_d;
      aborted_q   <= aborted_d;
      err_q       <= err_d;
      ap_idle_q   <= ap_idle_d;
      ap_done_q   <= ap_done_d;
    end
  end

  assign ap_idle    = ap_idle_q;
  assign ap_ready   = ap_idle_q;
  assign ap_done    = ap_done_q;
  assign best_x     = best_x_q;
  assign best_y     = best_y_q;
  assign best_cost  = best_cost_q;
  assign eval_cnt   = eval_cnt_q;
  assign aborted    = aborted_q;
  assign err_sticky = err_q;

endmodule
